fpga_device: RTL and testbench

FPGA_DEVICE -- requirements
Module: fpga_device

---
 rtl/smart_uart_pkg.sv | 43 ++++
 rtl/smart_uart_rx.sv | 106 ++++++++++
 rtl/fpga_device.sv | 219 +++++++++++++++++++++
 tb/tb_fpga_device.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/smart_uart_pkg.sv
// Shared types, ASCII constants and helpers for the smart UART device.
// Contents: RX/TX/decoder state enums, reply/event byte constants,
// bit-period computation and hex <-> ASCII helpers.
package smart_uart_pkg;

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic       {DEC_IDLE, DEC_WAIT_ARG} dec_state_t;

  localparam logic [7:0] ASCII_L     = 8'h4C;
  localparam logic [7:0] ASCII_QUERY = 8'h3F;
  localparam logic [7:0] ASCII_B     = 8'h42;
  localparam logic [7:0] ASCII_K     = 8'h4B;
  localparam logic [7:0] ASCII_BANG  = 8'h21;
  localparam logic [7:0] ASCII_P     = 8'h50;
  localparam logic [7:0] ASCII_R     = 8'h52;
  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_1     = 8'h31;

  // Rounded bit period in clock cycles.
  function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

  function automatic logic is_hex(input logic [7:0] b);
    return ((b >= 8'h30) && (b <= 8'h39)) ||
           ((b >= 8'h41) && (b <= 8'h46)) ||
           ((b >= 8'h61) && (b <= 8'h66));
  endfunction

  function automatic logic [3:0] hex_val(input logic [7:0] b);
    logic [7:0] v;
    if (b <= 8'h39)      v = b - 8'h30;
    else if (b >= 8'h61) v = b - 8'h57;
    else                 v = b - 8'h37;
    return v[3:0];
  endfunction

  function automatic logic [7:0] to_hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

endpackage

// File: rtl/smart_uart_rx.sv
// UART receiver: 2-flop synchronizer, mid-bit sampling, parity/framing check.
// Ports: clk/rst (async active-high), rx_i serial in (idle high),
//        valid_o 1-cycle good-byte pulse with data_o, err_o 1-cycle bad-frame pulse.
module smart_uart_rx
  import smart_uart_pkg::*;
#(
  parameter int unsigned DIV       = 434,
  parameter bit          PARITY_EN = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic       valid_o,
  output logic [7:0] data_o,
  output logic       err_o
);

  localparam int unsigned CNT_W = $clog2(DIV + 1);
  localparam int unsigned HALF  = DIV / 2;

  logic [1:0]       sync_q;
  logic             prev_q;
  rx_state_t        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_q;
  logic [7:0]       shift_q;
  logic             par_err_q;
  logic             rx_s;

  assign rx_s = sync_q[1];

  // Receive FSM; a start is only recognised on a 1->0 transition of the synchronized line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= 2'b11;
      prev_q    <= 1'b1;
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_err_q <= 1'b0;
      valid_o   <= 1'b0;
      data_o    <= '0;
      err_o     <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rx_i};
      prev_q  <= rx_s;
      valid_o <= 1'b0;
      err_o   <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          cnt_q <= '0;
          if (prev_q && !rx_s) begin
            state_q   <= RX_START;
            par_err_q <= 1'b0;
          end
        end
        RX_START: begin
          if (cnt_q == CNT_W'(HALF - 1)) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            // Line back high at mid start bit: treat as a glitch.
            state_q <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (cnt_q == CNT_W'(DIV - 1)) begin
            cnt_q   <= '0;
            shift_q <= {rx_s, shift_q[7:1]};
            if (bit_q == 3'd7) state_q <= PARITY_EN ? RX_PARITY : RX_STOP;
            else               bit_q   <= bit_q + 3'd1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RX_PARITY: begin
          if (cnt_q == CNT_W'(DIV - 1)) begin
            cnt_q     <= '0;
            par_err_q <= rx_s ^ (^shift_q);
            state_q   <= RX_STOP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (cnt_q == CNT_W'(DIV - 1)) begin
            cnt_q   <= '0;
            state_q <= RX_IDLE;
            if (rx_s && !par_err_q) begin
              valid_o <= 1'b1;
              data_o  <= shift_q;
            end else begin
              err_o <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/fpga_device.sv
// Smart UART device: command decoder driving an LED register, debounced
// button events, and a UART transmitter arbitrating reply and event slots.
// Ports: brd_clk, brd_rst (async active-high), brd_gp_button (raw, 1=pressed),
//        uart_rx / uart_tx (idle high), led (4-bit register).
module fpga_device
  import smart_uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ     = 50000000,
  parameter int unsigned BAUDRATE        = 115200,
  parameter bit          PARITY_EN       = 1'b0,
  parameter int unsigned DEBOUNCE_CYCLES = 4096
) (
  input  logic       brd_clk,
  input  logic       brd_rst,
  input  logic       brd_gp_button,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic [3:0] led
);

  localparam int unsigned DIV   = calc_div(CLK_FREQ_HZ, BAUDRATE);
  localparam int unsigned CNT_W = $clog2(DIV + 1);
  localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES + 1);

  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_err;

  smart_uart_rx #(.DIV(DIV), .PARITY_EN(PARITY_EN)) u_rx (
    .clk    (brd_clk),
    .rst    (brd_rst),
    .rx_i   (uart_rx),
    .valid_o(rx_valid),
    .data_o (rx_data),
    .err_o  (rx_err)
  );

  // Command decoder: produces at most one reply byte per received frame.
  dec_state_t dec_state_q;
  logic [3:0] led_q;
  logic       reply_vld_q;
  logic [7:0] reply_byte_q;
  logic       db_level_q;

  always_ff @(posedge brd_clk or posedge brd_rst) begin
    if (brd_rst) begin
      dec_state_q  <= DEC_IDLE;
      led_q        <= '0;
      reply_vld_q  <= 1'b0;
      reply_byte_q <= '0;
    end else begin
      reply_vld_q <= 1'b0;
      if (rx_err) begin
        reply_vld_q  <= 1'b1;
        reply_byte_q <= ASCII_BANG;
      end else if (rx_valid) begin
        case (dec_state_q)
          DEC_IDLE: begin
            if (rx_data == ASCII_L) begin
              dec_state_q <= DEC_WAIT_ARG;
            end else begin
              reply_vld_q <= 1'b1;
              if (rx_data == ASCII_QUERY)  reply_byte_q <= to_hex_ascii(led_q);
              else if (rx_data == ASCII_B) reply_byte_q <= db_level_q ? ASCII_1 : ASCII_0;
              else                         reply_byte_q <= rx_data;
            end
          end
          DEC_WAIT_ARG: begin
            dec_state_q <= DEC_IDLE;
            reply_vld_q <= 1'b1;
            if (is_hex(rx_data)) begin
              led_q        <= hex_val(rx_data);
              reply_byte_q <= ASCII_K;
            end else begin
              reply_byte_q <= ASCII_BANG;
            end
          end
          default: dec_state_q <= DEC_IDLE;
        endcase
      end
    end
  end

  // Button debouncer; a level change is accepted only after an unbroken run of disagreement.
  logic [1:0]      btn_sync_q;
  logic [DB_W-1:0] db_cnt_q;
  logic            evt_vld_q;
  logic [7:0]      evt_byte_q;

  always_ff @(posedge brd_clk or posedge brd_rst) begin
    if (brd_rst) begin
      btn_sync_q <= '0;
      db_cnt_q   <= '0;
      db_level_q <= 1'b0;
      evt_vld_q  <= 1'b0;
      evt_byte_q <= '0;
    end else begin
      btn_sync_q <= {btn_sync_q[0], brd_gp_button};
      evt_vld_q  <= 1'b0;
      if (btn_sync_q[1] != db_level_q) begin
        if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          db_cnt_q   <= '0;
          db_level_q <= btn_sync_q[1];
          evt_vld_q  <= 1'b1;
          evt_byte_q <= btn_sync_q[1] ? ASCII_P : ASCII_R;
        end else begin
          db_cnt_q <= db_cnt_q + DB_W'(1);
        end
      end else begin
        db_cnt_q <= '0;
      end
    end
  end

  // Slot arbitration: reply has priority whenever the transmitter is idle.
  tx_state_t tx_state_q;
  logic      reply_full_q, event_full_q;
  logic [7:0] reply_q, event_q;
  logic       take_reply_c, take_event_c;
  logic [7:0] tx_load_c;

  always_comb begin
    take_reply_c = 1'b0;
    take_event_c = 1'b0;
    tx_load_c    = reply_q;
    if (tx_state_q == TX_IDLE) begin
      if (reply_full_q) begin
        take_reply_c = 1'b1;
      end else if (event_full_q) begin
        take_event_c = 1'b1;
        tx_load_c    = event_q;
      end
    end
  end

  // Replies arriving while the slot is occupied are dropped; events overwrite.
  always_ff @(posedge brd_clk or posedge brd_rst) begin
    if (brd_rst) begin
      reply_full_q <= 1'b0;
      reply_q      <= '0;
      event_full_q <= 1'b0;
      event_q      <= '0;
    end else begin
      if (reply_vld_q && (!reply_full_q || take_reply_c)) begin
        reply_full_q <= 1'b1;
        reply_q      <= reply_byte_q;
      end else if (take_reply_c) begin
        reply_full_q <= 1'b0;
      end
      if (evt_vld_q) begin
        event_full_q <= 1'b1;
        event_q      <= evt_byte_q;
      end else if (take_event_c) begin
        event_full_q <= 1'b0;
      end
    end
  end

  // Transmit FSM with registered serial output.
  logic [CNT_W-1:0] tx_cnt_q;
  logic [2:0]       tx_bit_q;
  logic [7:0]       tx_sh_q;
  logic             tx_par_q;
  logic             uart_tx_q;

  always_ff @(posedge brd_clk or posedge brd_rst) begin
    if (brd_rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      tx_par_q   <= 1'b0;
      uart_tx_q  <= 1'b1;
    end else begin
      if (tx_state_q == TX_IDLE) begin
        tx_cnt_q <= '0;
        if (take_reply_c || take_event_c) begin
          tx_sh_q    <= tx_load_c;
          tx_par_q   <= ^tx_load_c;
          uart_tx_q  <= 1'b0;
          tx_state_q <= TX_START;
        end
      end else if (tx_cnt_q != CNT_W'(DIV - 1)) begin
        tx_cnt_q <= tx_cnt_q + CNT_W'(1);
      end else begin
        tx_cnt_q <= '0;
        case (tx_state_q)
          TX_START: begin
            uart_tx_q  <= tx_sh_q[0];
            tx_bit_q   <= '0;
            tx_state_q <= TX_DATA;
          end
          TX_DATA: begin
            if (tx_bit_q == 3'd7) begin
              uart_tx_q  <= PARITY_EN ? tx_par_q : 1'b1;
              tx_state_q <= PARITY_EN ? TX_PARITY : TX_STOP;
            end else begin
              uart_tx_q <= tx_sh_q[1];
              tx_sh_q   <= {1'b0, tx_sh_q[7:1]};
              tx_bit_q  <= tx_bit_q + 3'd1;
            end
          end
          TX_PARITY: begin
            uart_tx_q  <= 1'b1;
            tx_state_q <= TX_STOP;
          end
          default: begin
            uart_tx_q  <= 1'b1;
            tx_state_q <= TX_IDLE;
          end
        endcase
      end
    end
  end

  assign uart_tx = uart_tx_q;
  assign led     = led_q;

endmodule

// File: tb/tb_fpga_device.sv
// Directed bench for fpga_device at a reduced clock/baud ratio (bit period 10 cycles)
// and a short debounce window. Instance u_dut has no parity; u_par has even parity.
module tb_fpga_device;

  localparam int DIV          = 10;   // (1_000_000 + 50_000) / 100_000
  localparam int DEB          = 40;
  localparam int RECV_TIMEOUT = 40 * DIV;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn0, btn1;
  logic       rx0, rx1;
  logic       tx0, tx1;
  logic [3:0] led0, led1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fpga_device #(.CLK_FREQ_HZ(1000000), .BAUDRATE(100000), .PARITY_EN(1'b0),
                .DEBOUNCE_CYCLES(DEB)) u_dut (
    .brd_clk(clk), .brd_rst(rst), .brd_gp_button(btn0),
    .uart_rx(rx0), .uart_tx(tx0), .led(led0));

  fpga_device #(.CLK_FREQ_HZ(1000000), .BAUDRATE(100000), .PARITY_EN(1'b1),
                .DEBOUNCE_CYCLES(DEB)) u_par (
    .brd_clk(clk), .brd_rst(rst), .brd_gp_button(btn1),
    .uart_rx(rx1), .uart_tx(tx1), .led(led1));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic get_tx(input bit sel);
    return sel ? tx1 : tx0;
  endfunction

  task automatic drive(input bit sel, input logic v);
    if (sel) rx1 = v;
    else     rx0 = v;
  endtask

  // Serialize one frame, changing the line on falling clock edges.
  task automatic send(input bit sel, input logic [7:0] b, input bit use_par, input bit par);
    @(negedge clk);
    drive(sel, 1'b0);
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      drive(sel, b[i]);
      repeat (DIV) @(negedge clk);
    end
    if (use_par) begin
      drive(sel, par);
      repeat (DIV) @(negedge clk);
    end
    drive(sel, 1'b1);
    repeat (DIV) @(negedge clk);
  endtask

  // Capture one frame; every bit must hold its value from its first to its last cycle.
  task automatic recv(input bit sel, output logic [7:0] b, output bit ok);
    bit          found;
    int          nb;
    logic [10:0] bits;
    logic        first, last;
    nb    = sel ? 11 : 10;
    found = 1'b0;
    ok    = 1'b1;
    b     = 8'hxx;
    bits  = '0;
    for (int i = 0; i < RECV_TIMEOUT && !found; i++) begin
      @(negedge clk);
      if (get_tx(sel) === 1'b0) found = 1'b1;
    end
    if (!found) begin
      ok = 1'b0;
      return;
    end
    for (int k = 0; k < nb; k++) begin
      if (k != 0) @(negedge clk);
      first = get_tx(sel);
      repeat (DIV - 1) @(negedge clk);
      last = get_tx(sel);
      if (first !== last) ok = 1'b0;
      bits[k] = last;
    end
    b = bits[8:1];
    if (bits[0] !== 1'b0) ok = 1'b0;
    if (bits[nb-1] !== 1'b1) ok = 1'b0;
    if (sel && (bits[9] !== ^bits[8:1])) ok = 1'b0;
  endtask

  task automatic send_expect(input string tag, input bit sel, input logic [7:0] b,
                             input bit use_par, input bit par, input logic [7:0] exp);
    logic [7:0] got;
    bit         ok;
    fork
      send(sel, b, use_par, par);
      recv(sel, got, ok);
    join
    chk({tag, "_frame"}, 8'(ok), 8'h01);
    chk(tag, got, exp);
  endtask

  task automatic expect_frame(input string tag, input logic [7:0] exp);
    logic [7:0] got;
    bit         ok;
    recv(1'b0, got, ok);
    chk({tag, "_frame"}, 8'(ok), 8'h01);
    chk(tag, got, exp);
  endtask

  task automatic quiet(input string tag, input int n);
    logic idle;
    idle = 1'b1;
    repeat (n) begin
      @(negedge clk);
      if (tx0 !== 1'b1) idle = 1'b0;
    end
    chk(tag, 8'(idle), 8'h01);
  endtask

  initial begin
    logic [7:0] g0, g1;
    bit         k0, k1;
    bit         found;
    rst  = 1'b1;
    rx0  = 1'b1;
    rx1  = 1'b1;
    btn0 = 1'b0;
    btn1 = 1'b0;

    // Reset held for 10 cycles.
    repeat (10) begin
      @(negedge clk);
      chk("rst_tx", 8'(tx0), 8'h01);
      chk("rst_led", 8'(led0), 8'h00);
    end
    rst = 1'b0;
    quiet("post_rst_idle", 5);
    chk("post_rst_led", 8'(led0), 8'h00);

    // LED load sequence and query.
    send(1'b0, 8'h4C, 1'b0, 1'b0);
    quiet("L_no_reply", 3 * DIV);
    send_expect("L_A_ack", 1'b0, 8'h41, 1'b0, 1'b0, 8'h4B);
    chk("led_A", 8'(led0), 8'h0A);
    send_expect("query_A", 1'b0, 8'h3F, 1'b0, 1'b0, 8'h41);

    // Bad argument leaves LED alone.
    send(1'b0, 8'h4C, 1'b0, 1'b0);
    send_expect("L_Z_bang", 1'b0, 8'h5A, 1'b0, 1'b0, 8'h21);
    chk("led_kept", 8'(led0), 8'h0A);

    // Echo with exact bit timing.
    send_expect("echo_55", 1'b0, 8'h55, 1'b0, 1'b0, 8'h55);

    // Framing error: stop bit low.
    fork
      begin
        @(negedge clk);
        rx0 = 1'b0;
        repeat (10 * DIV) @(negedge clk);
        rx0 = 1'b1;
        repeat (DIV) @(negedge clk);
      end
      recv(1'b0, g0, k0);
    join
    chk("framing_frame", 8'(k0), 8'h01);
    chk("framing_bang", g0, 8'h21);

    // Parity instance: wrong parity then correct parity.
    send_expect("par_bad", 1'b1, 8'h07, 1'b1, 1'b0, 8'h21);
    send_expect("par_good", 1'b1, 8'h07, 1'b1, 1'b1, 8'h07);

    // Button press / release events and level query.
    fork
      btn0 = 1'b1;
      expect_frame("evt_P", 8'h50);
    join
    send_expect("B_pressed", 1'b0, 8'h42, 1'b0, 1'b0, 8'h31);
    fork
      btn0 = 1'b0;
      expect_frame("evt_R", 8'h52);
    join
    send_expect("B_released", 1'b0, 8'h42, 1'b0, 1'b0, 8'h30);

    // Short glitch below the debounce window.
    btn0 = 1'b1;
    repeat (10) @(negedge clk);
    btn0 = 1'b0;
    quiet("glitch_no_evt", 150);
    send_expect("B_after_glitch", 1'b0, 8'h42, 1'b0, 1'b0, 8'h30);

    // Press lands while the query reply is being sent: reply first, then event.
    fork
      send(1'b0, 8'h3F, 1'b0, 1'b0);
      begin
        repeat (9 * DIV) @(negedge clk);
        btn0 = 1'b1;
      end
      begin
        recv(1'b0, g0, k0);
        recv(1'b0, g1, k1);
      end
    join
    chk("arb_first_frame", 8'(k0), 8'h01);
    chk("arb_first", g0, 8'h41);
    chk("arb_second_frame", 8'(k1), 8'h01);
    chk("arb_second", g1, 8'h50);
    fork
      btn0 = 1'b0;
      expect_frame("evt_R2", 8'h52);
    join

    // Reset in the middle of a transmitted reply.
    fork
      send(1'b0, 8'h3F, 1'b0, 1'b0);
      begin
        found = 1'b0;
        for (int i = 0; i < RECV_TIMEOUT && !found; i++) begin
          @(negedge clk);
          if (tx0 === 1'b0) found = 1'b1;
        end
        chk("midtx_started", 8'(found), 8'h01);
        repeat (3 * DIV) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midtx_rst_tx", 8'(tx0), 8'h01);
        chk("midtx_rst_led", 8'(led0), 8'h00);
      end
    join
    repeat (10) @(negedge clk);
    rst = 1'b0;
    quiet("midtx_idle", 3 * DIV);
    send_expect("query_after_rst", 1'b0, 8'h3F, 1'b0, 1'b0, 8'h30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
